// File: rtl/mutex_system_n.sv
// mutex_system_n: N symmetric nodes (Idle/Try/Crit/Exit) sharing one lock bit.
// Each cycle at most one guarded rule is selected through io_en_a; the block
// reports whether it fired or was rejected, keeps a sticky mutual-exclusion
// violation flag and counts fired rules with a saturating counter.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   io_en_a      in   SEL_W  rule select (0 = no-op, r -> node (r-1)/4, rule (r-1)%4)
//   io_state     out  2*NODES  node states, node i at [2i+1:2i] (I=0,T=1,C=2,E=3)
//   io_x         out  lock bit, 1 = free
//   io_fired     out  pulse: last selection had a true guard and was applied
//   io_rejected  out  pulse: last selection was nonzero but not applied
//   io_violation out  sticky: two or more nodes seen in C at once
//   io_steps     out  CNT_W  saturating count of fired rules
module mutex_system_n #(
    parameter int unsigned NODES = 3,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned SEL_W = $clog2(4 * NODES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SEL_W-1:0]     io_en_a,
    output logic [2*NODES-1:0]   io_state,
    output logic                 io_x,
    output logic                 io_fired,
    output logic                 io_rejected,
    output logic                 io_violation,
    output logic [CNT_W-1:0]     io_steps
);

    localparam int unsigned NODE_W = SEL_W - 2;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_T = 2'd1;
    localparam logic [1:0] ST_C = 2'd2;
    localparam logic [1:0] ST_E = 2'd3;

    logic [NODES-1:0][1:0] state_q, state_d;
    logic                  x_q, x_d;
    logic                  fired_q, fired_d;
    logic                  rejected_q, rejected_d;
    logic                  violation_q, violation_d;
    logic [CNT_W-1:0]      steps_q, steps_d;

    logic [SEL_W-1:0]      rule_idx;
    logic [NODE_W-1:0]     node_sel;
    logic [1:0]            kind;
    logic                  in_range;
    logic                  one_c;
    logic                  multi_c;

    // Rule decode, guard evaluation, violation monitor and step counter.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        fired_d     = 1'b0;
        rejected_d  = 1'b0;
        violation_d = violation_q;
        steps_d     = steps_q;
        one_c       = 1'b0;
        multi_c     = 1'b0;

        rule_idx = io_en_a - SEL_W'(1);
        node_sel = rule_idx[SEL_W-1:2];
        kind     = rule_idx[1:0];
        // Padding encodings above 4*NODES select no node at all.
        in_range = (io_en_a != '0) && (io_en_a <= SEL_W'(4 * NODES));

        for (int unsigned i = 0; i < NODES; i++) begin
            if (in_range && (node_sel == NODE_W'(i))) begin
                case (kind)
                    2'd0: if (state_q[i] == ST_I) begin
                        state_d[i] = ST_T;
                        fired_d    = 1'b1;
                    end
                    2'd1: if ((state_q[i] == ST_T) && x_q) begin
                        state_d[i] = ST_C;
                        x_d        = 1'b0;
                        fired_d    = 1'b1;
                    end
                    2'd2: if (state_q[i] == ST_C) begin
                        state_d[i] = ST_E;
                        fired_d    = 1'b1;
                    end
                    default: if (state_q[i] == ST_E) begin
                        state_d[i] = ST_I;
                        x_d        = 1'b1;
                        fired_d    = 1'b1;
                    end
                endcase
            end
            // A second node in C while one was already seen marks a violation.
            if (state_q[i] == ST_C) begin
                multi_c = multi_c | one_c;
                one_c   = 1'b1;
            end
        end

        rejected_d  = (io_en_a != '0) && !fired_d;
        violation_d = violation_q | multi_c;
        if (fired_d && (steps_q != '1)) begin
            steps_d = steps_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= '0;
            x_q         <= 1'b1;
            fired_q     <= 1'b0;
            rejected_q  <= 1'b0;
            violation_q <= 1'b0;
            steps_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            fired_q     <= fired_d;
            rejected_q  <= rejected_d;
            violation_q <= violation_d;
            steps_q     <= steps_d;
        end
    end

    assign io_state     = state_q;
    assign io_x         = x_q;
    assign io_fired     = fired_q;
    assign io_rejected  = rejected_q;
    assign io_violation = violation_q;
    assign io_steps     = steps_q;

endmodule

// File: tb/tb_mutex_system_n.sv
// Testbench for mutex_system_n: a default 3-node instance checked against an
// array-based reference model, a 4-bit counter instance for saturation and a
// 5-node instance for the widened select.
module tb_mutex_system_n;

    localparam int unsigned N = 3;

    logic        clock;
    logic        reset;

    logic [3:0]  en_a;
    logic [5:0]  st3;
    logic        x3, f3, r3, v3;
    logic [15:0] s3;

    logic [3:0]  en_s;
    logic [5:0]  sts;
    logic        xs, fs, rs, vs;
    logic [3:0]  ss;

    logic [4:0]  en5;
    logic [9:0]  st5;
    logic        x5, f5, r5, v5;
    logic [15:0] s5;

    int checks = 0;
    int errors = 0;

    // Reference model state for the 3-node instance.
    int   m_st[N];
    bit   m_x;
    bit   m_fired, m_rej, m_viol;
    int   m_steps;

    mutex_system_n #(.NODES(3), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .io_en_a(en_a), .io_state(st3), .io_x(x3),
        .io_fired(f3), .io_rejected(r3), .io_violation(v3), .io_steps(s3)
    );

    mutex_system_n #(.NODES(3), .CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .io_en_a(en_s), .io_state(sts), .io_x(xs),
        .io_fired(fs), .io_rejected(rs), .io_violation(vs), .io_steps(ss)
    );

    mutex_system_n #(.NODES(5), .CNT_W(16)) dut5 (
        .clock(clock), .reset(reset), .io_en_a(en5), .io_state(st5), .io_x(x5),
        .io_fired(f5), .io_rejected(r5), .io_violation(v5), .io_steps(s5)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_st[i] = 0;
        m_x = 1'b1; m_fired = 1'b0; m_rej = 1'b0; m_viol = 1'b0; m_steps = 0;
    endfunction

    // Apply one selection according to the rule table.
    function automatic void model_apply(input int r);
        int  i, k;
        bit  ok;
        m_fired = 1'b0;
        m_rej   = 1'b0;
        if (r == 0) return;
        if (r > 4 * N) begin
            m_rej = 1'b1;
            return;
        end
        i  = (r - 1) / 4;
        k  = (r - 1) % 4;
        ok = 1'b0;
        if (k == 0 && m_st[i] == 0) begin m_st[i] = 1; ok = 1'b1; end
        else if (k == 1 && m_st[i] == 1 && m_x) begin m_st[i] = 2; m_x = 1'b0; ok = 1'b1; end
        else if (k == 2 && m_st[i] == 2) begin m_st[i] = 3; ok = 1'b1; end
        else if (k == 3 && m_st[i] == 3) begin m_st[i] = 0; m_x = 1'b1; ok = 1'b1; end
        m_fired = ok;
        m_rej   = !ok;
        if (ok && m_steps < 65535) m_steps++;
    endfunction

    function automatic logic [25:0] exp_main();
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s | (6'(m_st[i]) << (2 * i));
        return {s, m_x, m_fired, m_rej, m_viol, 16'(m_steps)};
    endfunction

    function automatic logic [25:0] obs_main();
        return {st3, x3, f3, r3, v3, s3};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        en_a = '0; en_s = '0; en5 = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step_main(input int r);
        en_a = 4'(r);
        @(posedge clock);
        #1;
        en_a = '0;
        model_apply(r);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_main() !== exp_main()) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", obs_main(), exp_main());
        end
    endtask

    task automatic test_node_cycle();
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            step_main(r);
            checks++;
            if (obs_main() !== exp_main()) begin
                errors++;
                $display("FAIL node_cycle r=%0d: got %h want %h", r, obs_main(), exp_main());
            end
        end
        checks++;
        if (s3 !== 16'd4) begin
            errors++;
            $display("FAIL node_cycle_steps: got %0d want 4", s3);
        end
    endtask

    task automatic test_lock_contention();
        int seq[4] = '{1, 5, 2, 6};
        do_reset();
        foreach (seq[j]) begin
            step_main(seq[j]);
            checks++;
            if (obs_main() !== exp_main()) begin
                errors++;
                $display("FAIL contention r=%0d: got %h want %h", seq[j], obs_main(), exp_main());
            end
        end
        checks++;
        if ({r3, st3[3:2], x3, v3} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL contention_reject: got rej=%b n1=%0d x=%b viol=%b want 1 1 0 0",
                     r3, st3[3:2], x3, v3);
        end
    endtask

    task automatic test_false_guard();
        int seq[4] = '{3, 13, 14, 15};
        do_reset();
        foreach (seq[j]) begin
            step_main(seq[j]);
            checks++;
            if (obs_main() !== exp_main() || r3 !== 1'b1 || s3 !== 16'd0) begin
                errors++;
                $display("FAIL false_guard r=%0d: got %h want %h", seq[j], obs_main(), exp_main());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step_main(1);
        step_main(2);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_main() !== exp_main()) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs_main(), exp_main());
        end
        #2;
        reset = 1'b0;
        step_main(5);
        checks++;
        if (obs_main() !== exp_main() || st3 !== 6'b000100) begin
            errors++;
            $display("FAIL after_reset r=5: got %h want %h", obs_main(), exp_main());
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 15);
            step_main(r);
            checks++;
            if (obs_main() !== exp_main()) begin
                errors++;
                $display("FAIL random n=%0d r=%0d: got %h want %h", n, r, obs_main(), exp_main());
            end
        end
    endtask

    task automatic test_violation();
        do_reset();
        force dut.state_q = 6'b001010;
        #1;
        checks++;
        if (v3 !== 1'b0) begin
            errors++;
            $display("FAIL violation_latency: got %b want 0", v3);
        end
        @(posedge clock);
        #1;
        checks++;
        if (v3 !== 1'b1) begin
            errors++;
            $display("FAIL violation_set: got %b want 1", v3);
        end
        release dut.state_q;
        for (int n = 0; n < 6; n++) begin
            en_a = 4'($urandom_range(0, 12));
            @(posedge clock);
            #1;
            checks++;
            if (v3 !== 1'b1) begin
                errors++;
                $display("FAIL violation_sticky n=%0d: got %b want 1", n, v3);
            end
        end
        en_a = '0;
        do_reset();
        checks++;
        if (obs_main() !== exp_main()) begin
            errors++;
            $display("FAIL violation_clear: got %h want %h", obs_main(), exp_main());
        end
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            en_s = 4'(((n - 1) % 4) + 1);
            @(posedge clock);
            #1;
            want = (n > 15) ? 15 : n;
            checks++;
            if (ss !== 4'(want) || fs !== 1'b1) begin
                errors++;
                $display("FAIL saturation n=%0d: got steps=%0d fired=%b want %0d 1", n, ss, fs, want);
            end
        end
        en_s = '0;
    endtask

    task automatic test_nodes5();
        int exp_n[4] = '{1, 2, 3, 0};
        bit exp_x[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int bad[2]   = '{21, 31};
        do_reset();
        for (int j = 0; j < 4; j++) begin
            en5 = 5'(17 + j);
            @(posedge clock);
            #1;
            checks++;
            if (st5 !== (10'(exp_n[j]) << 8) || x5 !== exp_x[j] || f5 !== 1'b1 || s5 !== 16'(j + 1)) begin
                errors++;
                $display("FAIL nodes5 r=%0d: got st=%h x=%b f=%b steps=%0d want st=%h x=%b f=1 steps=%0d",
                         17 + j, st5, x5, f5, s5, 10'(exp_n[j]) << 8, exp_x[j], j + 1);
            end
        end
        foreach (bad[j]) begin
            en5 = 5'(bad[j]);
            @(posedge clock);
            #1;
            checks++;
            if (r5 !== 1'b1 || f5 !== 1'b0 || st5 !== 10'd0 || s5 !== 16'd4) begin
                errors++;
                $display("FAIL nodes5_range r=%0d: got rej=%b f=%b st=%h steps=%0d want 1 0 0 4",
                         bad[j], r5, f5, st5, s5);
            end
        end
        en5 = '0;
    endtask

    initial begin
        reset = 1'b1;
        en_a = '0; en_s = '0; en5 = '0;
        model_reset();
        test_reset();
        test_node_cycle();
        test_lock_contention();
        test_false_guard();
        test_async_reset();
        test_random();
        test_violation();
        test_saturation();
        test_nodes5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mutex_system_n.md
# mutex_system_n

Parametrised successor of the generated three-node mutual-exclusion system: N symmetric nodes, each a 4-state machine (Idle, Try, Crit, Exit), share one lock bit `x`. Each cycle the external driver (formal engine or testbench) selects at most one guarded rule through `io_en_a`. The block adds what the fixed three-node version lacks: node count as a parameter, a fired/rejected status, a sticky mutual-exclusion violation monitor and a step counter. It is the top-level DUT for the mutual-exclusion equivalence and trace benches.

## Interface
- `NODES`, 3: number of nodes; legal range 2..16.
- `CNT_W`, 16: width of the step counter.
- Derived: `SEL_W = $clog2(4*NODES+1)`, which is 4 for `NODES=3`.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `io_en_a`  in  SEL_W  rule select: 0 = no-op; r in 1..4*NODES fires rule k=(r-1)%4 of node i=(r-1)/4.
- `io_state`  out  2*NODES  node states; node i occupies bits [2i+1:2i]; encoding I=0, T=1, C=2, E=3.
- `io_x`  out  1  lock bit; 1 = free.
- `io_fired`  out  1  registered pulse: the previous cycle's selected rule had a true guard and was applied.
- `io_rejected`  out  1  registered pulse: the previous cycle's selection was nonzero but its guard was false or r > 4*NODES.
- `io_violation`  out  1  sticky flag: more than one node has been in C at the same time.
- `io_steps`  out  CNT_W  count of fired rules; saturates at all-ones.

## Operation
- Rules for node i (k = 0..3):
  - k=0 Try: guard n[i]=I; action n[i]:=T.
  - k=1 Crit: guard n[i]=T and x=1; action n[i]:=C, x:=0.
  - k=2 Exit: guard n[i]=C; action n[i]:=E.
  - k=3 Idle: guard n[i]=E; action n[i]:=I, x:=1.
- At most one rule fires per cycle. A false guard leaves all state unchanged and causes `io_rejected`.
- An out-of-range select (r > 4*NODES, including encodings unused because of power-of-two padding) changes nothing and causes `io_rejected`.
- `io_en_a`=0 changes nothing; both pulses are 0 on the following cycle.
- Violation monitor: evaluated on the registered `io_state` every cycle. If the count of nodes in C is 2 or more, `io_violation` is set and stays set until reset. With correct rules this must never happen; the monitor exists so the formal flow can assert `!io_violation`.
- Step counter: increments by 1 on every fired rule and holds at 2^CNT_W-1.
- Reset values: all nodes I (`io_state`=0), `io_x`=1, `io_fired`=0, `io_rejected`=0, `io_violation`=0, `io_steps`=0.

## Timing
- `io_en_a` is sampled on rising edge t. The new `io_state`/`io_x`, the `io_fired`/`io_rejected` pulse and the incremented `io_steps` are all visible after edge t, so the latency is 1 cycle.
- Guards are evaluated on the current registered state, so two consecutive Crit selects for different nodes see the lock already taken by the first: the second is rejected.
- `io_violation` is registered from `io_state`: it sets 1 cycle after the offending state appears.
- Asserting `reset` mid-operation forces all reset values immediately, without waiting for a clock edge. On the first edge after deassertion, `io_en_a` is honoured normally.
- All outputs are registers; there is no combinational path from input to output.

## Test plan
- Reset, then r=1, 2, 3, 4 on consecutive cycles (NODES=3) -> node 0 steps T, C, E, I; `io_x` goes 1, 0, 0, 1; `io_fired`=1 four times; `io_steps`=4.
- r=1, r=5, r=2, r=6 -> node 0 enters C with `io_x`=0; node 1's Crit (r=6) gives `io_rejected`=1 with node 1 held in T; `io_violation` stays 0.
- Reset, then r=3 (Exit while Idle) -> `io_rejected`=1, state unchanged, `io_steps`=0. Then r=13, 14, 15 (out of range) -> `io_rejected`=1 on each.
- Drive r=1, 2 to put node 0 in C, then assert `reset` between edges -> `io_state`=0 and `io_x`=1 immediately. After release, r=5 -> node 1 enters T.
- Force two nodes into C via testbench register initialisation -> `io_violation`=1 one cycle later and it stays 1 through subsequent legal rules until reset.
- CNT_W=4, with 20 fired rules -> `io_steps` saturates at 15; NODES=5 with r=17..20 -> node 4 runs a full cycle.
